// File: rtl/info_regs_streamer_if.sv
// Stream and register-input bundle for info_regs_streamer.
// The master modport is the streamer; the slave modport is the register source and byte sink.
`timescale 1ns/1ps
interface info_regs_streamer_if;
    logic [31:0] majVerIn;
    logic [31:0] minVerIn;
    logic [31:0] gitHashIn;
    logic        reqIn;
    logic        busyOut;
    logic [7:0]  byteOut;
    logic        validOut;
    logic        readyIn;
    logic        doneOut;

    modport master (
        input  majVerIn, minVerIn, gitHashIn, reqIn, readyIn,
        output busyOut, byteOut, validOut, doneOut
    );

    modport slave (
        output majVerIn, minVerIn, gitHashIn, reqIn, readyIn,
        input  busyOut, byteOut, validOut, doneOut
    );
endinterface

// File: rtl/info_regs_streamer.sv
// Serializes major/minor version and git hash into a framed valid/ready byte stream.
// Define INFO_STREAM_CSUM_EN to append an 8-bit modular-sum checksum byte to each frame.
`timescale 1ns/1ps
module info_regs_streamer (
    input  logic                 clkIn,
    input  logic                 rstNegIn,
    info_regs_streamer_if.master bus
);
    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam int         REG_WIDTH    = 32;
    localparam int         SNAP_WIDTH   = 3 * REG_WIDTH;
    localparam logic [3:0] LAST_PAYLOAD = 4'd11;

`ifdef INFO_STREAM_CSUM_EN
    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, PAYLOAD} state_t;
`endif

    state_t                  state_reg;
    logic [SNAP_WIDTH-1:0]   shift_reg;
    logic [3:0]              cnt_reg;
    logic [7:0]              byte_reg;
    logic                    valid_reg;
    logic                    busy_reg;
    logic                    done_reg;
`ifdef INFO_STREAM_CSUM_EN
    logic [7:0]              acc_reg;
`endif

    always_ff @(posedge clkIn or negedge rstNegIn) begin
        if (!rstNegIn) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            byte_reg  <= 8'h00;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef INFO_STREAM_CSUM_EN
            acc_reg   <= 8'h00;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.reqIn) begin
                        // Snapshot all three registers at once so the frame is coherent.
                        shift_reg <= {bus.majVerIn, bus.minVerIn, bus.gitHashIn};
                        cnt_reg   <= '0;
`ifdef INFO_STREAM_CSUM_EN
                        acc_reg   <= 8'h00;
`endif
                        byte_reg  <= SYNC_BYTE;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= SYNC;
                    end
                end
                SYNC: begin
                    if (bus.readyIn) begin
                        byte_reg  <= shift_reg[SNAP_WIDTH-1 -: 8];
                        shift_reg <= shift_reg << 8;
                        state_reg <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (bus.readyIn) begin
                        cnt_reg <= cnt_reg + 4'd1;
`ifdef INFO_STREAM_CSUM_EN
                        acc_reg <= acc_reg + byte_reg;
`endif
                        if (cnt_reg == LAST_PAYLOAD) begin
`ifdef INFO_STREAM_CSUM_EN
                            // Include the byte leaving on this beat in the checksum.
                            byte_reg  <= acc_reg + byte_reg;
                            state_reg <= CSUM;
`else
                            byte_reg  <= 8'h00;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= IDLE;
`endif
                        end else begin
                            byte_reg  <= shift_reg[SNAP_WIDTH-1 -: 8];
                            shift_reg <= shift_reg << 8;
                        end
                    end
                end
`ifdef INFO_STREAM_CSUM_EN
                CSUM: begin
                    if (bus.readyIn) begin
                        byte_reg  <= 8'h00;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    byte_reg  <= 8'h00;
                end
            endcase
        end
    end

    assign bus.busyOut  = busy_reg;
    assign bus.byteOut  = byte_reg;
    assign bus.validOut = valid_reg;
    assign bus.doneOut  = done_reg;
endmodule

// File: tb/tb_info_regs_streamer.sv
// Scoreboard bench for info_regs_streamer: frames are built from the register values and
// compared byte by byte as the stream is accepted, along with handshake and done timing.
`timescale 1ns/1ps
module tb_info_regs_streamer;
    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    logic clk;
    logic rst_n;
    info_regs_streamer_if bus ();

    info_regs_streamer dut (
        .clkIn    (clk),
        .rstNegIn (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   pending_done = 0;
    bit   stall_prev = 0;
    logic [7:0] stall_byte = 8'h00;
    int   done_seen = 0;
    int   frames_expected = 0;
    int   ready_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference frame: sync, big-endian registers, optional sum of payload bytes.
    task automatic push_frame(input logic [31:0] maj, input logic [31:0] mnr, input logic [31:0] hash);
        logic [31:0] regs [3];
        int sum;
        exp_t e;
        regs[0] = maj; regs[1] = mnr; regs[2] = hash;
        sum = 0;
        e.b = 8'hA5; e.last = 0; sb.push_back(e);
        for (int r = 0; r < 3; r++) begin
            for (int k = 3; k >= 0; k--) begin
                e.b = 8'((regs[r] >> (8 * k)) & 32'hFF);
                sum = sum + int'(e.b);
`ifdef INFO_STREAM_CSUM_EN
                e.last = 0;
`else
                e.last = (r == 2 && k == 0);
`endif
                sb.push_back(e);
            end
        end
`ifdef INFO_STREAM_CSUM_EN
        e.b = 8'(sum % 256); e.last = 1; sb.push_back(e);
`endif
        frames_expected++;
    endtask

    // Monitor: checks handshake state and pops the scoreboard on every beat.
    always @(negedge clk) begin
        if (rst_n) begin
            bit exp_busy;
            exp_busy = (sb.size() != 0);
            chk("done", {31'd0, bus.doneOut}, {31'd0, pending_done});
            if (bus.doneOut) done_seen++;
            if (pending_done) chk("byte_after_done", {24'd0, bus.byteOut}, 32'h0);
            chk("busy", {31'd0, bus.busyOut}, {31'd0, exp_busy});
            chk("valid", {31'd0, bus.validOut}, {31'd0, exp_busy});
            if (stall_prev) chk("stall_byte", {24'd0, bus.byteOut}, {24'd0, stall_byte});
            stall_prev = 0;
            if (bus.validOut && bus.readyIn) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", {24'd0, bus.byteOut}, 32'hFFFF_FFFF);
                    pending_done = 0;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("stream_byte", {24'd0, bus.byteOut}, {24'd0, e.b});
                    pending_done = e.last;
                end
            end else begin
                pending_done = 0;
            end
            if (bus.validOut && !bus.readyIn) begin
                stall_prev = 1;
                stall_byte = bus.byteOut;
            end
        end
    end

    // Sink ready pattern: 0 always ready, 1 toggling, 2 random.
    initial begin
        bus.readyIn = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.readyIn = 1'b1;
                1: bus.readyIn = ~bus.readyIn;
                default: bus.readyIn = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || pending_done) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            chk("drain_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
            pending_done = 0;
        end
    endtask

    task automatic run_frame(input logic [31:0] maj, input logic [31:0] mnr, input logic [31:0] hash,
                             input int mode);
        wait_drain();
        ready_mode = mode;
        bus.majVerIn  = maj;
        bus.minVerIn  = mnr;
        bus.gitHashIn = hash;
        bus.reqIn     = 1'b1;
        tick();
        bus.reqIn = 1'b0;
        push_frame(maj, mnr, hash);
        $display("frame maj=%h min=%h hash=%h ready_mode=%0d", maj, mnr, hash, mode);
    endtask

    initial begin
        rst_n = 1'b1;
        bus.reqIn = 1'b0;
        bus.majVerIn = '0;
        bus.minVerIn = '0;
        bus.gitHashIn = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy",  {31'd0, bus.busyOut},  32'h0);
        chk("reset_valid", {31'd0, bus.validOut}, 32'h0);
        chk("reset_byte",  {24'd0, bus.byteOut},  32'h0);
        chk("reset_done",  {31'd0, bus.doneOut},  32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic frame, then the same frame under toggling backpressure.
        run_frame(32'h0000_0001, 32'h0000_0002, 32'hDEAD_BEEF, 0);
        run_frame(32'h0000_0001, 32'h0000_0002, 32'hDEAD_BEEF, 1);

        // Snapshot coherency: input changes mid-frame must not leak in.
        run_frame(32'h0000_0001, 32'h0000_0002, 32'hDEAD_BEEF, 0);
        repeat (4) tick();
        bus.gitHashIn = 32'h1234_5678;
        run_frame(32'h0000_0001, 32'h0000_0002, 32'h1234_5678, 0);

        // A request while busy is ignored: no restart, no extra frame.
        run_frame(32'hCAFE_0001, 32'h0BAD_F00D, 32'h0102_0304, 0);
        repeat (6) tick();
        bus.reqIn = 1'b1;
        tick();
        bus.reqIn = 1'b0;
        wait_drain();
        repeat (3) tick();
        chk("no_second_frame", 32'(sb.size()), 32'h0);

        // Reset during payload byte 7 abandons the frame immediately.
        run_frame(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 0);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  {31'd0, bus.busyOut},  32'h0);
        chk("midrst_valid", {31'd0, bus.validOut}, 32'h0);
        chk("midrst_byte",  {24'd0, bus.byteOut},  32'h0);
        chk("midrst_done",  {31'd0, bus.doneOut},  32'h0);
        sb.delete();
        pending_done = 0;
        stall_prev = 0;
        frames_expected--;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_frame(32'h0000_0001, 32'h0000_0002, 32'hDEAD_BEEF, 0);

        // Randomized frames under random backpressure.
        for (int i = 0; i < 20; i++) begin
            run_frame($urandom, $urandom, $urandom, (i % 3 == 0) ? 1 : 2);
        end
        wait_drain();
        repeat (3) tick();
        chk("done_count", 32'(done_seen), 32'(frames_expected));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/info_regs_streamer.md
# info_regs_streamer

Serializes the build-information registers (major version, minor version, git hash; 32 bits each) into a framed byte stream on request. It is the read-out end of the info-register set: top-level logic supplies the register values, and this block delivers them byte by byte to a host-facing transport (UART TX, debug FIFO) over a valid/ready interface. Register values are snapshotted when a request is accepted, so each frame is internally coherent.

## Interface
- SYNC_BYTE, 8'hA5: first byte of every frame.
- REG_WIDTH, 32: width of each info register. Fixed at 32; other values are unsupported.
- clkIn  input  1  sole clock; all logic is on its rising edge.
- rstNegIn  input  1  reset, asynchronous and active-low.
- majVerIn  input  32  major version value.
- minVerIn  input  32  minor version value.
- gitHashIn  input  32  collected git hash value.
- reqIn  input  1  frame request; sampled only while busyOut is low.
- busyOut  output  1  a frame is in progress.
- byteOut  output  8  current stream byte.
- validOut  output  1  byteOut holds a valid byte.
- readyIn  input  1  the sink accepts byteOut this cycle.
- doneOut  output  1  one-cycle pulse after the final byte is accepted.

## Operation
- A byte transfers on a rising edge where validOut=1 and readyIn=1 (a "beat").
- While validOut=1, byteOut is stable until its beat; validOut never drops without a beat.
- Frame order:
  - SYNC_BYTE.
  - 12 payload bytes, big-endian per register, in the order majVer, minVer, gitHash.
  - Optional checksum byte; see Configuration.
- Checksum: 8-bit modular sum of the 12 payload bytes; SYNC is excluded; carries are discarded.
- States:
  - IDLE: reqIn=1 snapshots the three inputs into a 96-bit shift register, clears the byte counter and checksum accumulator, then goes to SYNC.
  - SYNC: beat goes to PAYLOAD.
  - PAYLOAD: each beat advances the 4-bit counter and adds the byte to the accumulator. The beat on byte 11 goes to CSUM if enabled, otherwise to IDLE.
  - CSUM: beat goes to IDLE.
- reqIn while busyOut=1 is ignored; requests are not queued.
- Input changes after the snapshot do not affect the frame in flight.
- Reset (async assert, any state): go to IDLE and abandon the frame. No partial byte is reissued after reset.

## Timing
- Reset values: busyOut=0, validOut=0, byteOut=8'h00, doneOut=0; snapshot, counter and accumulator all zero.
- reqIn=1 in IDLE at edge N: busyOut=1 and validOut=1 with byteOut=SYNC_BYTE from edge N.
- With readyIn held at 1: one byte per cycle. The frame occupies 14 cycles, or 13 with the checksum compiled out.
- Final beat at edge M: at edge M busyOut=0, validOut=0, doneOut=1, byteOut=8'h00. doneOut clears at M+1.
- Back-to-back frames: reqIn=1 in the doneOut cycle starts the next frame at M+1. There is one idle cycle minimum between frames.
- readyIn low stalls indefinitely with no state change; there is no timeout.

## Configuration
- INFO_STREAM_CSUM_EN defined: the CSUM state exists and the frame is 14 bytes.
- INFO_STREAM_CSUM_EN undefined: no CSUM state and no accumulator logic. The frame is 13 bytes and PAYLOAD goes directly to IDLE.

## Test plan
- Basic frame (CSUM_EN defined): maj=0x00000001, min=0x00000002, hash=0xDEADBEEF, readyIn=1, single req.
  - Required stream: A5 00 00 00 01 00 00 00 02 DE AD BE EF 3B on 14 consecutive cycles.
  - Required doneOut: one pulse after the 3B beat.
- Backpressure: same frame, readyIn toggling 1/0 each cycle.
  - Required: identical 14-byte sequence.
  - Required: byteOut and validOut stable during every stalled cycle.
- Snapshot coherency: change gitHashIn to 0x12345678 mid-frame.
  - Required: the frame still carries DE AD BE EF and checksum 3B.
  - Required: a subsequent request carries 12 34 56 78.
- Ignored request: pulse reqIn during payload byte 5.
  - Required: no restart and no second frame.
  - Required: exactly one doneOut pulse.
- Reset mid-frame: assert rstNegIn low during byte 7.
  - Required: all outputs zero immediately.
  - Required: after release, a new req yields a complete frame starting with A5.
- Checksum compiled out (INFO_STREAM_CSUM_EN undefined): same stimulus as the basic frame.
  - Required: 13 bytes ending at EF.
  - Required: doneOut on the following cycle.
